// File: rtl/way_age_tracker.sv
// way_age_tracker
//   Keeps a saturating age counter and a valid bit per way. Accesses age every
//   other valid way and zero the accessed one; invalidates and flushes clear
//   ways. Ages are exported flattened (way i at [i*W +: W]) for select_biggest.
//   The tracker also registers its own victim choice: the lowest-index invalid
//   way if any exists, otherwise the oldest way (ties go to the lowest index).
//
// Ports
//   clk_in, reset_in          clock (rising edge), async active-low reset
//   access_valid_in/way_in    access request / accessed way
//   access_ready_out          high in IDLE, low while flushing
//   invalidate_in/way_in      invalidate request / target way
//   flush_in                  start a flush (sampled in IDLE only)
//   flush_done_out            one-cycle pulse after the last way is cleared
//   valid_out                 per-way valid bits
//   way_flatted_out           per-way ages, flattened
//   victim_way_out/age_out    registered victim choice and its age
//   victim_is_invalid_out     victim is an invalid way
//
// Optional build macro
//   WAY_AGE_TRACKER_TICK_EN   adds age_tick_in: ages all valid ways in IDLE.
//
// state | meaning
// IDLE  | accepting access / invalidate / flush requests
// FLUSH | clearing one way per cycle, way[ptr], ptr = 0 .. NUM_WAY-1

module way_age_tracker #(
   parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
   parameter int NUM_WAY                  = 16,
   parameter int NUM_WAY_INDEX_BITS       = 4
) (
   input  logic                                         clk_in,
   input  logic                                         reset_in,
   input  logic                                         access_valid_in,
   input  logic [NUM_WAY_INDEX_BITS-1:0]                access_way_in,
   output logic                                         access_ready_out,
   input  logic                                         invalidate_in,
   input  logic [NUM_WAY_INDEX_BITS-1:0]                invalidate_way_in,
   input  logic                                         flush_in,
`ifdef WAY_AGE_TRACKER_TICK_EN
   input  logic                                         age_tick_in,
`endif
   output logic                                         flush_done_out,
   output logic [NUM_WAY-1:0]                           valid_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
   output logic [NUM_WAY_INDEX_BITS-1:0]                victim_way_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          victim_age_out,
   output logic                                         victim_is_invalid_out
);

   localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
   localparam logic [W-1:0] AGE_MAX = '1;
   localparam logic [NUM_WAY_INDEX_BITS-1:0] LAST_WAY = NUM_WAY_INDEX_BITS'(NUM_WAY - 1);

   typedef enum logic [0:0] {IDLE, FLUSH} state_t;

   state_t                         state, state_nxt;
   logic [NUM_WAY_INDEX_BITS-1:0]  ptr, ptr_nxt;
   logic                           flush_done, flush_done_nxt;

   logic [W-1:0]                   age     [NUM_WAY];
   logic [W-1:0]                   age_nxt [NUM_WAY];
   logic [NUM_WAY-1:0]             valid, valid_nxt;

   logic                           take, acc, inv, tick;

   logic                           found_inv;
   logic [NUM_WAY_INDEX_BITS-1:0]  inv_idx, max_idx;
   logic [W-1:0]                   max_age;

   // Requests are only taken in IDLE, and never on the edge that starts a flush.
   assign take = (state == IDLE) && !flush_in;
   assign acc  = take && access_valid_in;
   assign inv  = take && invalidate_in;
`ifdef WAY_AGE_TRACKER_TICK_EN
   assign tick = take && age_tick_in;
`else
   assign tick = 1'b0;
`endif

   assign access_ready_out = (state == IDLE);
   assign flush_done_out   = flush_done;
   assign valid_out        = valid;

   always_comb begin
      way_flatted_out = '0;
      for (int i = 0; i < NUM_WAY; i++) begin
         way_flatted_out[i*W +: W] = age[i];
      end
   end

   // FSM next state
   always_comb begin
      state_nxt      = state;
      ptr_nxt        = ptr;
      flush_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (flush_in) begin
               state_nxt = FLUSH;
               ptr_nxt   = '0;
            end
         end
         FLUSH: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST_WAY) begin
               state_nxt      = IDLE;
               flush_done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-way update. Invalidate has priority over access on the same way;
   // aging (access or tick) increments each remaining valid way at most once.
   always_comb begin
      valid_nxt = valid;
      for (int i = 0; i < NUM_WAY; i++) begin
         age_nxt[i] = age[i];
         if (state == FLUSH) begin
            if (ptr == NUM_WAY_INDEX_BITS'(i)) begin
               age_nxt[i]   = '0;
               valid_nxt[i] = 1'b0;
            end
         end else if (inv && (invalidate_way_in == NUM_WAY_INDEX_BITS'(i))) begin
            age_nxt[i]   = '0;
            valid_nxt[i] = 1'b0;
         end else if (acc && (access_way_in == NUM_WAY_INDEX_BITS'(i))) begin
            age_nxt[i]   = '0;
            valid_nxt[i] = 1'b1;
         end else if (valid[i] && (acc || tick) && (age[i] != AGE_MAX)) begin
            age_nxt[i] = age[i] + 1'b1;
         end
      end
   end

   // Victim search on the current registered state.
   always_comb begin
      found_inv = 1'b0;
      inv_idx   = '0;
      for (int i = NUM_WAY - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            found_inv = 1'b1;
            inv_idx   = NUM_WAY_INDEX_BITS'(i);
         end
      end
      max_idx = '0;
      max_age = age[0];
      for (int i = 1; i < NUM_WAY; i++) begin
         // strict compare keeps the lowest index on ties
         if (age[i] > max_age) begin
            max_age = age[i];
            max_idx = NUM_WAY_INDEX_BITS'(i);
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state                 <= IDLE;
         ptr                   <= '0;
         flush_done            <= 1'b0;
         valid                 <= '0;
         for (int i = 0; i < NUM_WAY; i++) age[i] <= '0;
         victim_way_out        <= '0;
         victim_age_out        <= '0;
         victim_is_invalid_out <= 1'b1;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         flush_done <= flush_done_nxt;
         valid      <= valid_nxt;
         for (int i = 0; i < NUM_WAY; i++) age[i] <= age_nxt[i];
         victim_way_out        <= found_inv ? inv_idx : max_idx;
         victim_age_out        <= found_inv ? '0 : max_age;
         victim_is_invalid_out <= found_inv;
      end
   end

endmodule

// File: tb/tb_way_age_tracker.sv
// Directed bench for way_age_tracker (default parameters: W=4, 16 ways).

module tb_way_age_tracker;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        access_valid_in;
   logic [3:0]  access_way_in;
   logic        access_ready_out;
   logic        invalidate_in;
   logic [3:0]  invalidate_way_in;
   logic        flush_in;
`ifdef WAY_AGE_TRACKER_TICK_EN
   logic        age_tick_in = 1'b0;
`endif
   logic        flush_done_out;
   logic [15:0] valid_out;
   logic [63:0] way_flatted_out;
   logic [3:0]  victim_way_out;
   logic [3:0]  victim_age_out;
   logic        victim_is_invalid_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_in = ~clk_in;

   way_age_tracker dut (
      .clk_in                (clk_in),
      .reset_in              (reset_in),
      .access_valid_in       (access_valid_in),
      .access_way_in         (access_way_in),
      .access_ready_out      (access_ready_out),
      .invalidate_in         (invalidate_in),
      .invalidate_way_in     (invalidate_way_in),
      .flush_in              (flush_in),
`ifdef WAY_AGE_TRACKER_TICK_EN
      .age_tick_in           (age_tick_in),
`endif
      .flush_done_out        (flush_done_out),
      .valid_out             (valid_out),
      .way_flatted_out       (way_flatted_out),
      .victim_way_out        (victim_way_out),
      .victim_age_out        (victim_age_out),
      .victim_is_invalid_out (victim_is_invalid_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [3:0] age_of(input int i);
      return way_flatted_out[i*4 +: 4];
   endfunction

   initial begin
      reset_in          = 1'b0;
      access_valid_in   = 1'b0;
      access_way_in     = '0;
      invalidate_in     = 1'b0;
      invalidate_way_in = '0;
      flush_in          = 1'b0;
      #22;
      reset_in = 1'b1;
      step();

      // 1: reset state
      check("rst_valid",   valid_out, 0);
      check("rst_ages",    way_flatted_out, 0);
      check("rst_ready",   access_ready_out, 1);
      check("rst_done",    flush_done_out, 0);
      check("rst_vway",    victim_way_out, 0);
      check("rst_vage",    victim_age_out, 0);
      check("rst_vinv",    victim_is_invalid_out, 1);

      // 2: fill ways 0..15, way j ends at age 15-j
      for (int k = 0; k < 16; k++) begin
         access_valid_in = 1'b1;
         access_way_in   = 4'(k);
         step();
      end
      access_valid_in = 1'b0;
      check("fill_valid",  valid_out, 16'hFFFF);
      check("fill_age0",   age_of(0), 4'hF);
      check("fill_age14",  age_of(14), 4'h1);
      check("fill_age15",  age_of(15), 4'h0);
      check("fill_ages",   way_flatted_out, 64'h0123456789ABCDEF);
      step();
      check("fill_vway",   victim_way_out, 0);
      check("fill_vage",   victim_age_out, 4'hF);
      check("fill_vinv",   victim_is_invalid_out, 0);

      // 3: re-access way 0; way1 saturates, lowest index wins the tie-free max
      access_valid_in = 1'b1;
      access_way_in   = 4'd0;
      step();
      access_valid_in = 1'b0;
      check("acc0_age0",   age_of(0), 4'h0);
      check("acc0_age1",   age_of(1), 4'hF);
      check("acc0_age2",   age_of(2), 4'hE);
      check("acc0_age3",   age_of(3), 4'hD);
      check("acc0_ages",   way_flatted_out, 64'h123456789ABCDEF0);
      step();
      check("acc0_vway",   victim_way_out, 1);
      check("acc0_vage",   victim_age_out, 4'hF);
      check("acc0_vinv",   victim_is_invalid_out, 0);

      // 4: access + invalidate of way 7: invalidate wins, others still age
      access_valid_in   = 1'b1;
      access_way_in     = 4'd7;
      invalidate_in     = 1'b1;
      invalidate_way_in = 4'd7;
      step();
      access_valid_in = 1'b0;
      invalidate_in   = 1'b0;
      check("ai7_valid",   valid_out, 16'hFF7F);
      check("ai7_age7",    age_of(7), 4'h0);
      check("ai7_ages",    way_flatted_out, 64'h234567890BCDEFF1);
      step();
      check("ai7_vway",    victim_way_out, 7);
      check("ai7_vage",    victim_age_out, 0);
      check("ai7_vinv",    victim_is_invalid_out, 1);

      // 5: flush while an access to way 3 is held
      flush_in        = 1'b1;
      access_valid_in = 1'b1;
      access_way_in   = 4'd3;
      step();
      flush_in = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) step();
         check($sformatf("fl_ready%0d", c), access_ready_out, 0);
         check($sformatf("fl_done%0d", c),  flush_done_out, 0);
         check($sformatf("fl_v3_%0d", c),   valid_out[3], (c >= 4) ? 1'b0 : 1'b1);
      end
      step();
      check("fl_end_ready", access_ready_out, 1);
      check("fl_end_done",  flush_done_out, 1);
      check("fl_end_valid", valid_out, 0);
      check("fl_end_ages",  way_flatted_out, 0);
      access_valid_in = 1'b0;
      step();
      check("fl_post_done", flush_done_out, 0);
      check("fl_post_valid", valid_out, 0);
      check("fl_post_vinv", victim_is_invalid_out, 1);
      check("fl_post_vway", victim_way_out, 0);

      // 6: reset in the middle of flush cycle 5
      access_valid_in = 1'b1;
      access_way_in   = 4'd2;
      step();
      access_way_in   = 4'd5;
      step();
      access_valid_in = 1'b0;
      check("pre6_valid", valid_out, 16'h0024);
      check("pre6_ages",  way_flatted_out, 64'h0000000000000100);
      flush_in = 1'b1;
      step();
      flush_in = 1'b0;
      for (int c = 0; c < 4; c++) step();
      check("pre6_ready", access_ready_out, 0);
      #2;
      reset_in = 1'b0;
      #1;
      check("r6_ready",  access_ready_out, 1);
      check("r6_valid",  valid_out, 0);
      check("r6_ages",   way_flatted_out, 0);
      check("r6_done",   flush_done_out, 0);
      check("r6_vway",   victim_way_out, 0);
      check("r6_vinv",   victim_is_invalid_out, 1);
      step();
      step();
      #3;
      reset_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("r6_post_done%0d", c),  flush_done_out, 0);
         check($sformatf("r6_post_ready%0d", c), access_ready_out, 1);
      end
      check("r6_post_valid", valid_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
